alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_decode.sv | 116 +++++++++++
 rtl/alu_issue.sv | 141 ++++++++++++++
 tb/tb_alu_issue.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the single-issue ALU front end.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_GTU = 4'd5;
  localparam logic [3:0] ALU_LTU = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDSUB = 3'd0;
  localparam logic [2:0] F3_SLL    = 3'd1;
  localparam logic [2:0] F3_SLT    = 3'd2;
  localparam logic [2:0] F3_SLTU   = 3'd3;
  localparam logic [2:0] F3_XOR    = 3'd4;
  localparam logic [2:0] F3_SR     = 3'd5;
  localparam logic [2:0] F3_OR     = 3'd6;
  localparam logic [2:0] F3_AND    = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] SIGN_FLIP = 32'h8000_0000;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;
  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE} br_kind_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode for OP / OP-IMM / BRANCH into ALU operands and control.
// Signed compares (SLT/SLTI/BLT/BGE) are legal only when ALU_ISSUE_SIGNED_EN is defined.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [3:0]  alu_op,
  output br_kind_t    br_kind,
  output logic [31:0] br_tgt,
  output logic [4:0]  rd,
  output logic        wb,
  output logic        slt,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic        signed_cmp;
  logic        unused_rs1_idx;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign br_tgt = pc + imm_b;
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    op1        = rs1_val;
    op2        = rs2_val;
    alu_op     = ALU_ADD;
    br_kind    = BR_NONE;
    wb         = 1'b0;
    slt        = 1'b0;
    illegal    = 1'b0;
    signed_cmp = 1'b0;
    case (opcode)
      OPC_OP: begin
        wb = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADDSUB: alu_op = ALU_ADD;
            F3_SLL:    begin alu_op = ALU_SLL; op2 = {27'b0, rs2_val[4:0]}; end
            F3_SLT:    begin alu_op = ALU_LTU; slt = 1'b1; signed_cmp = 1'b1; end
            F3_SLTU:   begin alu_op = ALU_LTU; slt = 1'b1; end
            F3_XOR:    alu_op = ALU_XOR;
            F3_SR:     begin alu_op = ALU_SRL; op2 = {27'b0, rs2_val[4:0]}; end
            F3_OR:     alu_op = ALU_OR;
            default:   alu_op = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADDSUB) begin
          alu_op = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        wb  = 1'b1;
        op2 = imm_i;
        case (f3)
          F3_ADDSUB: alu_op = ALU_ADD;
          F3_SLT:    begin alu_op = ALU_LTU; slt = 1'b1; signed_cmp = 1'b1; end
          F3_SLTU:   begin alu_op = ALU_LTU; slt = 1'b1; end
          F3_XOR:    alu_op = ALU_XOR;
          F3_OR:     alu_op = ALU_OR;
          F3_AND:    alu_op = ALU_AND;
          F3_SLL:    begin alu_op = ALU_SLL; op2 = {27'b0, instr[24:20]}; illegal = (f7 != F7_BASE); end
          default:   begin alu_op = ALU_SRL; op2 = {27'b0, instr[24:20]}; illegal = (f7 != F7_BASE); end
        endcase
      end
      OPC_BRANCH: begin
        case (f3)
          F3_BEQ:  begin alu_op = ALU_SUB; br_kind = BR_EQ; end
          F3_BNE:  begin alu_op = ALU_SUB; br_kind = BR_NE; end
          F3_BLT:  begin alu_op = ALU_LTU; br_kind = BR_LT; signed_cmp = 1'b1; end
          F3_BGE:  begin alu_op = ALU_LTU; br_kind = BR_GE; signed_cmp = 1'b1; end
          F3_BLTU: begin alu_op = ALU_LTU; br_kind = BR_LT; end
          F3_BGEU: begin alu_op = ALU_LTU; br_kind = BR_GE; end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    // Flipping bit 31 maps signed order onto the ALU's unsigned compare.
`ifdef ALU_ISSUE_SIGNED_EN
    if (signed_cmp) begin
      op1 = op1 ^ SIGN_FLIP;
      op2 = op2 ^ SIGN_FLIP;
    end
`else
    if (signed_cmp) illegal = 1'b1;
`endif

    if (illegal) begin
      op1     = '0;
      op2     = '0;
      alu_op  = ALU_ADD;
      br_kind = BR_NONE;
      wb      = 1'b0;
      slt     = 1'b0;
    end
  end

  assign rd = wb ? instr[11:7] : 5'd0;

endmodule

// File: rtl/alu_issue.sv
// Issue stage: accepts one instruction, drives the external ALU for a cycle, returns a response.
// Optional signed compares are enabled with ALU_ISSUE_SIGNED_EN (see alu_decode).
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_branch,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        illegal
);

  logic [31:0] dec_op1, dec_op2, dec_tgt;
  logic [3:0]  dec_alu_op;
  br_kind_t    dec_br_kind;
  logic [4:0]  dec_rd;
  logic        dec_wb, dec_slt, dec_ill;

  alu_decode u_decode (
    .instr   (instr),
    .pc      (pc),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .op1     (dec_op1),
    .op2     (dec_op2),
    .alu_op  (dec_alu_op),
    .br_kind (dec_br_kind),
    .br_tgt  (dec_tgt),
    .rd      (dec_rd),
    .wb      (dec_wb),
    .slt     (dec_slt),
    .illegal (dec_ill)
  );

  state_t      state_q;
  logic        in_ready_q, out_valid_q;
  logic [31:0] op1_q, op2_q, tgt_q;
  logic [3:0]  alu_op_q;
  br_kind_t    br_kind_q;
  logic [4:0]  rd_q, rd_addr_q;
  logic        wb_q, slt_q, ill_q;
  logic [31:0] rd_data_q, br_target_q, rd_data_d, br_target_d;
  logic        rd_we_q, br_taken_q, illegal_q, rd_we_d, br_taken_d;

  // Response fields derived from the latched decode and the ALU's EXEC-cycle result.
  always_comb begin
    case (br_kind_q)
      BR_EQ:   br_taken_d = (alu_out == 32'd0);
      BR_NE:   br_taken_d = (alu_out != 32'd0);
      BR_LT:   br_taken_d = alu_branch;
      BR_GE:   br_taken_d = !alu_branch;
      default: br_taken_d = 1'b0;
    endcase
    br_target_d = br_taken_d ? tgt_q : 32'd0;
    rd_data_d   = !wb_q ? 32'd0 : (slt_q ? {31'b0, alu_branch} : alu_out);
    rd_we_d     = wb_q && (rd_q != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      alu_op_q    <= ALU_ADD;
      br_kind_q   <= BR_NONE;
      tgt_q       <= '0;
      rd_q        <= '0;
      wb_q        <= 1'b0;
      slt_q       <= 1'b0;
      ill_q       <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_we_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          op1_q      <= dec_op1;
          op2_q      <= dec_op2;
          alu_op_q   <= dec_alu_op;
          br_kind_q  <= dec_br_kind;
          tgt_q      <= dec_tgt;
          rd_q       <= dec_rd;
          wb_q       <= dec_wb;
          slt_q      <= dec_slt;
          ill_q      <= dec_ill;
          in_ready_q <= 1'b0;
          state_q    <= ST_EXEC;
        end
        ST_EXEC: begin
          rd_addr_q   <= rd_q;
          rd_data_q   <= rd_data_d;
          rd_we_q     <= rd_we_d;
          br_taken_q  <= br_taken_d;
          br_target_q <= br_target_d;
          illegal_q   <= ill_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        default: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign alu_op    = alu_op_q;
  assign rd_addr   = rd_addr_q;
  assign rd_data   = rd_data_q;
  assign rd_we     = rd_we_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ALU attached to op1/op2/alu_op.
module tb_alu_issue;

  logic        clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_val, rs2_val, op1, op2, alu_out, rd_data, br_target;
  logic [3:0]  alu_op;
  logic        alu_branch, rd_we, br_taken, illegal;
  logic [4:0]  rd_addr;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic        chk_ops;
    logic [31:0] op1, op2;
    logic [3:0]  alu_op;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we, br_taken;
    logic [31:0] br_target;
    logic        illegal;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  alu_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .op1(op1), .op2(op2), .alu_op(alu_op), .alu_out(alu_out), .alu_branch(alu_branch),
    .out_valid(out_valid), .out_ready(out_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_we(rd_we), .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
  );

  // Reference ALU
  always_comb begin
    alu_branch = (alu_op == 4'd5) ? (op1 > op2) : (op1 < op2);
    case (alu_op)
      4'd0:    alu_out = op1 + op2;
      4'd1:    alu_out = op1 - op2;
      4'd2:    alu_out = op1 & op2;
      4'd3:    alu_out = op1 | op2;
      4'd4:    alu_out = op1 ^ op2;
      4'd5:    alu_out = {31'b0, alu_branch};
      4'd6:    alu_out = {31'b0, alu_branch};
      4'd7:    alu_out = op1 >> op2[4:0];
      4'd8:    alu_out = op1 << op2[4:0];
      default: alu_out = 32'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic add(input logic [31:0] i_instr, input logic [31:0] i_pc, input logic [31:0] i_rs1,
                     input logic [31:0] i_rs2, input logic ck, input logic [31:0] e_op1,
                     input logic [31:0] e_op2, input logic [3:0] e_aop, input logic [4:0] e_rda,
                     input logic [31:0] e_rdd, input logic e_we, input logic e_tk,
                     input logic [31:0] e_tgt, input logic e_ill);
    vec_t v;
    v.instr = i_instr; v.pc = i_pc; v.rs1 = i_rs1; v.rs2 = i_rs2; v.chk_ops = ck;
    v.op1 = e_op1; v.op2 = e_op2; v.alu_op = e_aop; v.rd_addr = e_rda; v.rd_data = e_rdd;
    v.rd_we = e_we; v.br_taken = e_tk; v.br_target = e_tgt; v.illegal = e_ill;
    tbl.push_back(v);
  endtask

  task automatic add_illegal(input logic [31:0] i_instr, input logic [31:0] i_rs1, input logic [31:0] i_rs2);
    add(i_instr, 32'h0, i_rs1, i_rs2, 1'b0, 32'h0, 32'h0, 4'd0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_op1"}, op1, 32'h0);
    chk({p, "_op2"}, op2, 32'h0);
    chk({p, "_alu_op"}, {28'b0, alu_op}, 32'h0);
    chk({p, "_out_valid"}, {31'b0, out_valid}, 32'h0);
    chk({p, "_rd_addr"}, {27'b0, rd_addr}, 32'h0);
    chk({p, "_rd_data"}, rd_data, 32'h0);
    chk({p, "_rd_we"}, {31'b0, rd_we}, 32'h0);
    chk({p, "_br_taken"}, {31'b0, br_taken}, 32'h0);
    chk({p, "_br_target"}, br_target, 32'h0);
    chk({p, "_illegal"}, {31'b0, illegal}, 32'h0);
  endtask

  task automatic chk_fields(input string p, input vec_t e);
    chk({p, "_rd_addr"}, {27'b0, rd_addr}, {27'b0, e.rd_addr});
    chk({p, "_rd_data"}, rd_data, e.rd_data);
    chk({p, "_rd_we"}, {31'b0, rd_we}, {31'b0, e.rd_we});
    chk({p, "_br_taken"}, {31'b0, br_taken}, {31'b0, e.br_taken});
    chk({p, "_br_target"}, br_target, e.br_target);
    chk({p, "_illegal"}, {31'b0, illegal}, {31'b0, e.illegal});
  endtask

  // Pops the oldest expectation once out_valid is seen.
  task automatic check_resp(input string p);
    vec_t e;
    chk({p, "_out_valid"}, {31'b0, out_valid}, 32'h1);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_scoreboard: response with no expected entry", p);
    end else if (out_valid) begin
      e = sb.pop_front();
      chk_fields(p, e);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1; instr = v.instr; pc = v.pc; rs1_val = v.rs1; rs2_val = v.rs2;
  endtask

  task automatic scramble_inputs();
    in_valid = 1'b0; instr = $urandom; pc = $urandom; rs1_val = $urandom; rs2_val = $urandom;
  endtask

  // One full transaction; called at #1 after a posedge with the DUT idle.
  task automatic run_vec(input int idx);
    string p;
    vec_t v;
    p = $sformatf("v%0d", idx);
    v = tbl[idx];
    out_ready = 1'b1;
    drive(v);
    chk({p, "_in_ready"}, {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    sb.push_back(v);
    #1;
    scramble_inputs();
    chk({p, "_exec_out_valid"}, {31'b0, out_valid}, 32'h0);
    chk({p, "_exec_in_ready"}, {31'b0, in_ready}, 32'h0);
    if (v.chk_ops) begin
      chk({p, "_op1"}, op1, v.op1);
      chk({p, "_op2"}, op2, v.op2);
    end
    chk({p, "_alu_op"}, {28'b0, alu_op}, {28'b0, v.alu_op});
    @(posedge clk); #1;
    check_resp(p);
    @(posedge clk); #1;
    chk({p, "_done_out_valid"}, {31'b0, out_valid}, 32'h0);
    chk({p, "_done_in_ready"}, {31'b0, in_ready}, 32'h1);
  endtask

  initial begin
    vec_t v, e;
    int n_xfer, last;

    add(enc_i(12'hFFF, 5'd1, 3'd0, 5'd5), 32'h0, 32'h0, 32'h0,
        1'b1, 32'h0, 32'hFFFF_FFFF, 4'd0, 5'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0);
    add(enc_b(13'd16, 5'd2, 5'd1, 3'd1), 32'h100, 32'd7, 32'd7,
        1'b1, 32'd7, 32'd7, 4'd1, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    add(enc_b(13'd16, 5'd2, 5'd1, 3'd0), 32'h100, 32'd7, 32'd7,
        1'b1, 32'd7, 32'd7, 4'd1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h110, 1'b0);
`ifdef ALU_ISSUE_SIGNED_EN
    add(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 32'h0, 32'hFFFF_FFFF, 32'd1,
        1'b1, 32'h7FFF_FFFF, 32'h8000_0001, 4'd6, 5'd3, 32'd1, 1'b1, 1'b0, 32'h0, 1'b0);
    add(enc_b(13'd8, 5'd2, 5'd1, 3'd4), 32'h200, 32'hFFFF_FFFF, 32'd1,
        1'b1, 32'h7FFF_FFFF, 32'h8000_0001, 4'd6, 5'd0, 32'h0, 1'b0, 1'b1, 32'h208, 1'b0);
    add(enc_b(13'd8, 5'd2, 5'd1, 3'd5), 32'h200, 32'd1, 32'hFFFF_FFFF,
        1'b1, 32'h8000_0001, 32'h7FFF_FFFF, 4'd6, 5'd0, 32'h0, 1'b0, 1'b1, 32'h208, 1'b0);
    add(enc_i(12'hFFF, 5'd1, 3'd2, 5'd14), 32'h0, 32'hFFFF_FFFE, 32'h0,
        1'b1, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 4'd6, 5'd14, 32'd1, 1'b1, 1'b0, 32'h0, 1'b0);
`else
    add_illegal(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 32'hFFFF_FFFF, 32'd1);
    add_illegal(enc_b(13'd8, 5'd2, 5'd1, 3'd4), 32'hFFFF_FFFF, 32'd1);
    add_illegal(enc_b(13'd8, 5'd2, 5'd1, 3'd5), 32'd1, 32'hFFFF_FFFF);
    add_illegal(enc_i(12'hFFF, 5'd1, 3'd2, 5'd14), 32'hFFFF_FFFE, 32'h0);
`endif
    add_illegal(enc_i(12'h403, 5'd1, 3'd5, 5'd4), 32'h80, 32'h0);
    add_illegal(32'h0000_007F, 32'd3, 32'd4);
    add_illegal(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd15), 32'd3, 32'd4);
    add_illegal(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd16), 32'h8000_0000, 32'd1);
    add(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'h0, 32'd5, 32'd6,
        1'b1, 32'd5, 32'd6, 4'd0, 5'd0, 32'd11, 1'b0, 1'b0, 32'h0, 1'b0);
    add(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd7), 32'h0, 32'd5, 32'd6,
        1'b1, 32'd5, 32'd6, 4'd1, 5'd7, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0);
    add(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd8), 32'h0, 32'hFFFF_FFFF, 32'd1,
        1'b1, 32'hFFFF_FFFF, 32'd1, 4'd6, 5'd8, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    add(enc_i(12'h004, 5'd1, 3'd1, 5'd9), 32'h0, 32'd3, 32'h0,
        1'b1, 32'd3, 32'd4, 4'd8, 5'd9, 32'h30, 1'b1, 1'b0, 32'h0, 1'b0);
    add(enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd10), 32'h0, 32'h8000_0000, 32'h23,
        1'b1, 32'h8000_0000, 32'd3, 4'd7, 5'd10, 32'h1000_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    add(enc_i(12'h0F0, 5'd1, 3'd4, 5'd11), 32'h0, 32'hFF, 32'h0,
        1'b1, 32'hFF, 32'hF0, 4'd4, 5'd11, 32'h0F, 1'b1, 1'b0, 32'h0, 1'b0);
    add(enc_i(12'hFF0, 5'd1, 3'd7, 5'd12), 32'h0, 32'hFF, 32'h0,
        1'b1, 32'hFF, 32'hFFFF_FFF0, 4'd2, 5'd12, 32'hF0, 1'b1, 1'b0, 32'h0, 1'b0);
    add(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd13), 32'h0, 32'h0F, 32'hF0,
        1'b1, 32'h0F, 32'hF0, 4'd3, 5'd13, 32'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
    add(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd6), 32'h4, 32'd1, 32'd2,
        1'b1, 32'd1, 32'd2, 4'd6, 5'd0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    add(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd7), 32'h4, 32'd1, 32'd2,
        1'b1, 32'd1, 32'd2, 4'd6, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    add(enc_b(13'h020, 5'd2, 5'd1, 3'd1), 32'hFFFF_FFF0, 32'd1, 32'd2,
        1'b1, 32'd1, 32'd2, 4'd1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0);

    // Reset state
    reset = 1'b1; out_ready = 1'b1; scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_release_in_ready", {31'b0, in_ready}, 32'h1);

    for (int i = 0; i < tbl.size(); i++) run_vec(i);

    // Response held with out_ready low for 5 cycles
    out_ready = 1'b0;
    drive(tbl[0]);
    @(posedge clk);
    sb.push_back(tbl[0]);
    #1;
    scramble_inputs();
    @(posedge clk); #1;
    drive(tbl[2]);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_out_valid", k), {31'b0, out_valid}, 32'h1);
      chk($sformatf("stall%0d_in_ready", k), {31'b0, in_ready}, 32'h0);
      chk_fields($sformatf("stall%0d", k), tbl[0]);
      @(posedge clk); #1;
    end
    scramble_inputs();
    out_ready = 1'b1;
    check_resp("stall_release");
    @(posedge clk); #1;
    chk("stall_done_out_valid", {31'b0, out_valid}, 32'h0);
    chk("stall_done_in_ready", {31'b0, in_ready}, 32'h1);

    // Reset during EXEC discards the transaction
    drive(tbl[7]);
    @(posedge clk);
    sb.push_back(tbl[7]);
    #1;
    scramble_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    chk_zero("rst_exec");
    sb.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_exec_in_ready", {31'b0, in_ready}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_exec_quiet%0d", k), {31'b0, out_valid}, 32'h0);
    end

    // Reset during RESP drops the pending response
    out_ready = 1'b0;
    drive(tbl[0]);
    @(posedge clk); #1;
    scramble_inputs();
    @(posedge clk); #1;
    chk("rst_resp_pre_out_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_zero("rst_resp");
    reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_resp_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_resp_quiet", {31'b0, out_valid}, 32'h0);

    // Back-to-back requests: one accept every 3 cycles
    v = tbl[0];
    v.instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd1); v.pc = 32'h0; v.rs1 = 32'd1; v.rs2 = 32'd2;
    v.rd_addr = 5'd1; v.rd_data = 32'd3; v.rd_we = 1'b1; v.br_taken = 1'b0; v.br_target = 32'h0; v.illegal = 1'b0;
    drive(v);
    n_xfer = 0; last = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (in_ready) begin
        n_xfer++;
        sb.push_back(v);
        if (n_xfer > 1) chk($sformatf("b2b_gap%0d", n_xfer), c - last, 32'd3);
        last = c;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b2b_scoreboard: response at cycle %0d with no expected entry", c);
        end else begin
          e = sb.pop_front();
          chk($sformatf("b2b_c%0d_rd_data", c), rd_data, e.rd_data);
          chk($sformatf("b2b_c%0d_rd_we", c), {31'b0, rd_we}, {31'b0, e.rd_we});
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b_transfers", n_xfer, 32'd3);
    chk("b2b_sb_empty", sb.size(), 32'd0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
